// File: rtl/uart_rx_sampler.sv
// UART receiver: two-flop synchronized line, mid-bit 3-sample majority vote,
// 8N1 framing with early stop-bit decision and a BREAK hold state.
module uart_rx_sampler #(
   parameter int CLKS_PER_BIT = 1042
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data_rx,
   output logic       rx_done,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int H  = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] C_S0   = CW'(H - 1);
   localparam logic [CW-1:0] C_S1   = CW'(H);
   localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t        r_state;
   logic          r_sync1, r_sync2, r_prev;
   logic [1:0]    r_fill;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic          r_s0, r_s1;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_done, r_err;

   logic w_maj, w_fall, w_wrap, w_dec;

   assign w_maj  = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
   assign w_fall = r_prev & ~r_sync2;
   assign w_wrap = (r_cnt == C_LAST);
   assign w_dec  = (r_cnt == C_DEC);

   // r_prev is held at 0 until the synchronizer carries real line samples, so a
   // line already low at reset release is not mistaken for a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_fill  <= 2'b00;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_fill  <= {r_fill[0], 1'b1};
         r_prev  <= r_fill[1] ? r_sync2 : 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_s0    <= 1'b1;
         r_s1    <= 1'b1;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         if (r_state == START || r_state == DATA || r_state == STOP) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
            if (r_cnt == C_S0) r_s0 <= r_sync2;
            if (r_cnt == C_S1) r_s1 <= r_sync2;
         end else begin
            r_cnt <= '0;
         end
         case (r_state)
            IDLE: begin
               if (w_fall) r_state <= START;
            end
            START: begin
               if (w_dec && w_maj) r_state <= IDLE;
               else if (w_wrap)    r_state <= DATA;
            end
            DATA: begin
               if (w_dec) r_shift <= {w_maj, r_shift[7:1]};
               if (w_wrap) begin
                  r_idx <= r_idx + 3'd1;
                  if (r_idx == 3'd7) r_state <= STOP;
               end
            end
            STOP: begin
               // Decide at mid-bit and leave; the rest of the stop bit is idle time.
               if (w_dec) begin
                  if (w_maj) begin
                     r_data  <= r_shift;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= BREAK;
                  end
               end
            end
            BREAK: begin
               if (r_sync2) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign data_rx   = r_data;
   assign rx_done   = r_done;
   assign frame_err = r_err;
   assign rx_busy   = (r_state != IDLE);

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 1042, meaning clock cycles per bit; the legal minimum is 16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port rx, input, 1 bit: the serial line, asynchronous to clk, idle high.
REQ-005 The module SHALL have port data_rx, output, 8 bits: the last correctly framed byte.
REQ-006 The module SHALL have port rx_done, output, 1 bit: a one-cycle pulse when data_rx is updated.
REQ-007 The module SHALL have port frame_err, output, 1 bit: a one-cycle pulse when a stop bit is sampled low.
REQ-008 The module SHALL have port rx_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 rx SHALL pass through a two-flop synchronizer before use, with both flops reset to 1; synchronizer latency is 2 cycles.
REQ-010 The state machine SHALL have exactly these states: IDLE, START, DATA, STOP, BREAK.
REQ-011 In IDLE, a synchronized falling edge (previous sample 1, current sample 0) SHALL move the machine to START, with the bit counter at 0 in the first START cycle (t0).
REQ-012 The bit counter SHALL count 0..CLKS_PER_BIT-1 and then wrap to 0; each wrap advances START->DATA and DATA bit 7->STOP.
REQ-013 In each bit, with H = floor(CLKS_PER_BIT/2), the synchronized line SHALL be sampled at counts H-1, H and H+1, and the bit value is the 2-of-3 majority, decided at count H+1.
REQ-014 START, decided 1 (false start): the machine SHALL return to IDLE, with no output pulse and data_rx unchanged.
REQ-015 DATA: eight bits SHALL be shifted in LSB first, tracked by a 3-bit index 0..7.
REQ-016 STOP, decided 1 at count H+1: data_rx SHALL load the shift register, rx_done SHALL pulse on the next cycle, and the machine SHALL go directly to IDLE without waiting for the rest of the stop bit.
REQ-017 STOP, decided 0: frame_err SHALL pulse on the next cycle, data_rx SHALL remain unchanged, and the machine SHALL go to BREAK.
REQ-018 BREAK SHALL remain while the synchronized line is 0, and SHALL move to IDLE on the first cycle it is 1; no start is detected from BREAK.
REQ-019 Frame timing SHALL be: stop decision at t0 + 9*CLKS_PER_BIT + H + 1, and rx_done high exactly one cycle later.
REQ-020 rx_done and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per frame.
REQ-021 Back-to-back frames, where a new start edge arrives at any point after return to IDLE, SHALL be received with no lost byte.
REQ-022 data_rx SHALL hold its value indefinitely between rx_done pulses.
REQ-023 rx_busy SHALL be registered-state derived: high from t0 until the cycle after leaving STOP or BREAK.

Reset
REQ-024 While reset is high, the module SHALL hold: state=IDLE, counter=0, bit index=0, shift register=0x00, data_rx=0x00, rx_done=0, frame_err=0, rx_busy=0, and synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with no pulse on rx_done or frame_err.
REQ-026 After reset release, a line that is already low SHALL NOT produce a start until a 1->0 edge is seen.

Verification (CLKS_PER_BIT=16, H=8)
REQ-027 The bench SHALL cover: frame 0xA5 with stop=1 -> data_rx=0xA5, rx_done high only at t0+154, frame_err stays 0.
REQ-028 The bench SHALL cover: a 4-cycle low glitch on idle rx -> START entered, majority 1 -> IDLE, no pulses, data_rx unchanged.
REQ-029 The bench SHALL cover: frame 0x3C with stop=0 held low for 40 cycles -> one frame_err pulse, data_rx keeps its prior value, BREAK until rx=1, then IDLE.
REQ-030 The bench SHALL cover: frames 0x00 then 0xFF sent back-to-back with a 1-bit stop -> two rx_done pulses, data_rx=0x00 then 0xFF.
REQ-031 The bench SHALL cover: a single-cycle inverted sample at count H inside data bit 3 of 0x55 -> majority vote still yields 0x55.
REQ-032 The bench SHALL cover: reset pulsed during data bit 4 of 0x81 -> all outputs 0, no pulse; a following 0x81 frame is received correctly.
